// File: rtl/stack_pkg.sv
// Shared definitions for the stack engine: command opcodes, fault codes,
// controller state encoding and small opcode-classification helpers.
package stack_pkg;

    // Control-unit command opcodes; encodings 5..7 are rejected as illegal.
    typedef enum logic [2:0] {
        OP_PUSH    = 3'd0,
        OP_POP     = 3'd1,
        OP_SAVE    = 3'd2,
        OP_RESTORE = 3'd3,
        OP_SETSP   = 3'd4
    } op_e;

    // Reported with a faulted response.
    localparam logic [1:0] FC_NONE      = 2'b00;
    localparam logic [1:0] FC_OVERFLOW  = 2'b01;
    localparam logic [1:0] FC_UNDERFLOW = 2'b10;
    localparam logic [1:0] FC_ILLEGAL   = 2'b11;

    // Controller states.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_MEM   = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Opcodes that move data towards memory (stack grows downward).
    function automatic logic is_write_op(input logic [2:0] op);
        return (op == OP_PUSH) || (op == OP_SAVE);
    endfunction

    // Opcodes that move a whole context frame rather than a single word.
    function automatic logic is_multi_op(input logic [2:0] op);
        return (op == OP_SAVE) || (op == OP_RESTORE);
    endfunction

endpackage

// File: rtl/stack_bound_check.sv
// Combinational limit rules for stack commands: decides whether a command
// may proceed given the current depth, and which fault to report if not.
module stack_bound_check
    import stack_pkg::*;
#(
    parameter  int          DATA_W    = 16,
    parameter  int unsigned STACK_TOP = 'h0400,
    parameter  int          DEPTH     = 64,
    parameter  int          CTX_WORDS = 3,
    localparam int          DW        = $clog2(DEPTH + 1)
) (
    input  logic [2:0]        i_op,
    input  logic [DW-1:0]     i_depth,
    input  logic [DATA_W-1:0] i_cmd_data,
    output logic              o_ok,
    output logic [1:0]        o_fault_code
);

    localparam longint unsigned DEPTH_L  = 64'(DEPTH);
    localparam longint unsigned CTX_L    = 64'(CTX_WORDS);
    localparam longint unsigned TOP_L    = 64'(STACK_TOP);
    localparam longint unsigned BOTTOM_L = 64'(STACK_TOP) - 64'(DEPTH);

    longint unsigned w_depth;
    longint unsigned w_data;

    // Evaluate the rule for the latched opcode; widen to avoid wrap in the sums.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        o_ok         = 1'b0;
        o_fault_code = FC_NONE;
        w_depth      = 64'(i_depth);
        w_data       = 64'(i_cmd_data);
        case (i_op)
            OP_PUSH: begin
                if (w_depth < DEPTH_L) o_ok = 1'b1;
                else                   o_fault_code = FC_OVERFLOW;
            end
            OP_POP: begin
                if (w_depth > 64'd0) o_ok = 1'b1;
                else                 o_fault_code = FC_UNDERFLOW;
            end
            OP_SAVE: begin
                if (w_depth + CTX_L <= DEPTH_L) o_ok = 1'b1;
                else                            o_fault_code = FC_OVERFLOW;
            end
            OP_RESTORE: begin
                if (w_depth >= CTX_L) o_ok = 1'b1;
                else                  o_fault_code = FC_UNDERFLOW;
            end
            OP_SETSP: begin
                if (w_data >= BOTTOM_L && w_data <= TOP_L) o_ok = 1'b1;
                else                                       o_fault_code = FC_ILLEGAL;
            end
            default: o_fault_code = FC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/stack_engine.sv
// Hardware stack controller: serialises PUSH/POP and multi-word context
// SAVE/RESTORE onto the data-memory port of a full-descending stack, rejects
// overflow/underflow before any memory traffic and tracks a high-water mark.
module stack_engine
    import stack_pkg::*;
#(
    parameter  int          DATA_W    = 16,
    parameter  int          ADDR_W    = 16,
    parameter  int unsigned STACK_TOP = 'h0400,
    parameter  int          DEPTH     = 64,
    parameter  int          CTX_WORDS = 3,
    localparam int          DW        = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [DATA_W-1:0]             cmd_data,
    input  logic [CTX_WORDS*DATA_W-1:0]   ctx_in,
    output logic                          rsp_valid,
    output logic [DATA_W-1:0]             rsp_data,
    output logic [CTX_WORDS*DATA_W-1:0]   ctx_out,
    output logic                          fault,
    output logic [1:0]                    fault_code,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ack,
    output logic [ADDR_W-1:0]             sp,
    output logic [DW-1:0]                 depth,
    output logic [DW-1:0]                 max_depth
);

    localparam int                CW        = (CTX_WORDS > 1) ? $clog2(CTX_WORDS) : 1;
    localparam logic [ADDR_W-1:0] SP_RESET  = ADDR_W'(STACK_TOP);
    localparam logic [CW-1:0]     LAST_WORD = CW'(CTX_WORDS - 1);

    // Controller state and latched command.
    logic [1:0]        r_state;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_ctx_src [CTX_WORDS];

    // Architectural state and held results.
    logic [ADDR_W-1:0] r_sp;
    logic [DW-1:0]     r_max_depth;
    logic [CW-1:0]     r_cnt;
    logic              r_fault;
    logic [1:0]        r_fault_code;
    logic [DATA_W-1:0] r_rsp_data;
    logic [DATA_W-1:0] r_ctx_dst [CTX_WORDS];

    // Derived signals.
    logic              w_ok;
    logic [1:0]        w_fault_code;
    logic              w_is_write;
    logic              w_is_multi;
    logic              w_last;
    logic [CW-1:0]     w_rest_idx;
    logic [DATA_W-1:0] w_wdata;
    logic [DW-1:0]     w_depth;

    assign w_depth    = DW'(SP_RESET - r_sp);
    assign w_is_write = is_write_op(r_op);
    assign w_is_multi = is_multi_op(r_op);
    assign w_last     = !w_is_multi || (r_cnt == LAST_WORD);
    // RESTORE fills the frame from the highest word down so it mirrors SAVE.
    assign w_rest_idx = LAST_WORD - r_cnt;
    assign w_wdata    = (r_op == OP_SAVE) ? r_ctx_src[r_cnt] : r_data;

    stack_bound_check #(
        .DATA_W    (DATA_W),
        .STACK_TOP (STACK_TOP),
        .DEPTH     (DEPTH),
        .CTX_WORDS (CTX_WORDS)
    ) u_bound_check (
        .i_op         (r_op),
        .i_depth      (w_depth),
        .i_cmd_data   (r_data),
        .o_ok         (w_ok),
        .o_fault_code (w_fault_code)
    );

    // Command sequencing: accept, check limits, run the memory transfers, respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the small context arrays are reset along with everything
            // else because they drive outputs that must read zero after reset.
            r_state      <= S_IDLE;
            r_op         <= 3'd0;
            r_data       <= '0;
            r_sp         <= SP_RESET;
            r_cnt        <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
            r_rsp_data   <= '0;
            for (int i = 0; i < CTX_WORDS; i++) begin
                r_ctx_src[i] <= '0;
                r_ctx_dst[i] <= '0;
            end
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register sees the pre-edge values regardless of statement order.
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op         <= cmd_op;
                        r_data       <= cmd_data;
                        r_cnt        <= '0;
                        r_fault      <= 1'b0;
                        r_fault_code <= FC_NONE;
                        for (int i = 0; i < CTX_WORDS; i++) begin
                            r_ctx_src[i] <= ctx_in[i*DATA_W +: DATA_W];
                        end
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!w_ok) begin
                        r_fault      <= 1'b1;
                        r_fault_code <= w_fault_code;
                        r_state      <= S_RESP;
                    end else if (r_op == OP_SETSP) begin
                        r_sp    <= ADDR_W'(r_data);
                        r_state <= S_RESP;
                    end else begin
                        r_state <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (w_is_write) r_sp <= r_sp - ADDR_W'(1);
                        else            r_sp <= r_sp + ADDR_W'(1);
                        if (r_op == OP_POP)     r_rsp_data            <= mem_rdata;
                        if (r_op == OP_RESTORE) r_ctx_dst[w_rest_idx] <= mem_rdata;
                        if (w_last) r_state <= S_RESP;
                        else        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // High-water mark follows depth one cycle later; SETSP never lowers it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_max_depth <= '0;
        else if (w_depth > r_max_depth) r_max_depth <= w_depth;
    end

    // Memory port is driven only in MEM so reset drops the request at once.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (r_state == S_MEM) begin
            mem_req   = 1'b1;
            mem_we    = w_is_write;
            mem_addr  = w_is_write ? (r_sp - ADDR_W'(1)) : r_sp;
            mem_wdata = w_is_write ? w_wdata : '0;
        end
    end

    for (genvar g = 0; g < CTX_WORDS; g++) begin : g_ctx_out
        assign ctx_out[g*DATA_W +: DATA_W] = r_ctx_dst[g];
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign rsp_valid  = (r_state == S_RESP);
    assign fault      = rsp_valid && r_fault;
    assign fault_code = rsp_valid ? r_fault_code : FC_NONE;
    assign rsp_data   = r_rsp_data;
    assign sp         = r_sp;
    assign depth      = w_depth;
    assign max_depth  = r_max_depth;

endmodule

// File: tb/tb_stack_engine.sv
// Self-checking bench for stack_engine: directed scenarios followed by random
// commands, all compared against a word-level stack model and a memory model.
module tb_stack_engine;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int TOP       = 'h0400;
    localparam int DEPTH     = 64;
    localparam int CTX_WORDS = 3;
    localparam int DW        = $clog2(DEPTH + 1);

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } xfer_t;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [2:0]                  cmd_op;
    logic [DATA_W-1:0]           cmd_data;
    logic [CTX_WORDS*DATA_W-1:0] ctx_in;
    logic                        rsp_valid;
    logic [DATA_W-1:0]           rsp_data;
    logic [CTX_WORDS*DATA_W-1:0] ctx_out;
    logic                        fault;
    logic [1:0]                  fault_code;
    logic                        mem_req;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        mem_ack;
    logic [ADDR_W-1:0]           sp;
    logic [DW-1:0]               depth;
    logic [DW-1:0]               max_depth;

    logic resp_ack  = 1'b0;
    logic spur_ack  = 1'b0;
    int   mem_wait  = 0;
    int   wcnt      = 0;
    logic [15:0] ram [int];
    xfer_t       xfer_log [$];

    // Reference model state.
    int          m_sp;
    int          m_max;
    logic [15:0] m_rsp;
    logic [15:0] m_ctx [CTX_WORDS];
    logic [15:0] m_mem [int];
    xfer_t       exp_log [$];

    int n_vec = 0;
    int n_err = 0;

    assign mem_ack = resp_ack | spur_ack;

    stack_engine #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .STACK_TOP (TOP),
        .DEPTH     (DEPTH),
        .CTX_WORDS (CTX_WORDS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .ctx_in     (ctx_in),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .ctx_out    (ctx_out),
        .fault      (fault),
        .fault_code (fault_code),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .sp         (sp),
        .depth      (depth),
        .max_depth  (max_depth)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Unwritten memory holds an address-derived pattern in both memories.
    function automatic logic [15:0] init_val(input int a);
        return 16'(a * 37) ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] ram_rd(input int a);
        return ram.exists(a) ? ram[a] : init_val(a);
    endfunction

    function automatic logic [15:0] m_rd(input int a);
        return m_mem.exists(a) ? m_mem[a] : init_val(a);
    endfunction

    // Memory device: acks after mem_wait idle cycles, logs each completed access.
    always @(negedge clk) begin
        if (mem_req) begin
            if (wcnt >= mem_wait) begin
                resp_ack = 1'b1;
                wcnt     = 0;
                if (mem_we) begin
                    ram[int'(mem_addr)] = mem_wdata;
                    mem_rdata = '0;
                    xfer_log.push_back('{we: 1'b1, addr: mem_addr, data: mem_wdata});
                end else begin
                    mem_rdata = ram_rd(int'(mem_addr));
                    xfer_log.push_back('{we: 1'b0, addr: mem_addr, data: mem_rdata});
                end
            end else begin
                resp_ack = 1'b0;
                wcnt++;
            end
        end else begin
            resp_ack = 1'b0;
            wcnt     = 0;
        end
    end

    task automatic m_push(input logic [15:0] v);
        m_sp = m_sp - 1;
        m_mem[m_sp] = v;
        exp_log.push_back('{we: 1'b1, addr: 16'(m_sp), data: v});
    endtask

    task automatic m_pop(output logic [15:0] v);
        v = m_rd(m_sp);
        exp_log.push_back('{we: 1'b0, addr: 16'(m_sp), data: v});
        m_sp = m_sp + 1;
    endtask

    task automatic m_reset();
        m_sp  = TOP;
        m_max = 0;
        m_rsp = '0;
        for (int i = 0; i < CTX_WORDS; i++) m_ctx[i] = '0;
    endtask

    // Issue one command, predict its outcome with the model, and compare.
    task automatic do_cmd(input logic [2:0] op, input logic [15:0] data,
                          input logic [47:0] ctx, input bit junk);
        int          d, words, n, first_req, exp_lat;
        bit          got, exp_fault;
        logic [1:0]  exp_code;
        logic [15:0] v;

        d = TOP - m_sp;
        words = 0;
        exp_fault = 1'b0;
        exp_code = 2'b00;
        exp_log.delete();
        case (op)
            3'd0: if (d < DEPTH) begin m_push(data); words = 1; end
                  else begin exp_fault = 1'b1; exp_code = 2'b01; end
            3'd1: if (d > 0) begin m_pop(v); m_rsp = v; words = 1; end
                  else begin exp_fault = 1'b1; exp_code = 2'b10; end
            3'd2: if (d + CTX_WORDS <= DEPTH) begin
                      for (int i = 0; i < CTX_WORDS; i++) m_push(ctx[i*16 +: 16]);
                      words = CTX_WORDS;
                  end else begin exp_fault = 1'b1; exp_code = 2'b01; end
            3'd3: if (d >= CTX_WORDS) begin
                      for (int i = CTX_WORDS - 1; i >= 0; i--) begin m_pop(v); m_ctx[i] = v; end
                      words = CTX_WORDS;
                  end else begin exp_fault = 1'b1; exp_code = 2'b10; end
            3'd4: if (int'(data) >= TOP - DEPTH && int'(data) <= TOP) m_sp = int'(data);
                  else begin exp_fault = 1'b1; exp_code = 2'b11; end
            default: begin exp_fault = 1'b1; exp_code = 2'b11; end
        endcase
        if (TOP - m_sp > m_max) m_max = TOP - m_sp;
        exp_lat = (words > 0) ? 2 + words * (mem_wait + 1) : 2;

        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (!cmd_ready) check("ready_timeout", 64'(cmd_ready), 64'(1));
        xfer_log.delete();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        ctx_in    = ctx;
        @(posedge clk);
        #1;
        if (junk) begin
            cmd_op   = 3'($urandom);
            cmd_data = 16'($urandom);
            ctx_in   = {16'($urandom), 16'($urandom), 16'($urandom)};
        end else begin
            cmd_valid = 1'b0;
        end
        n = 0; first_req = 0; got = 1'b0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (mem_req && first_req == 0) first_req = n;
            if (rsp_valid) begin got = 1'b1; break; end
        end
        cmd_valid = 1'b0;

        check("rsp_seen",   64'(got),        64'(1));
        check("latency",    64'(n),          64'(exp_lat));
        check("first_req",  64'(first_req),  64'((words > 0) ? 2 : 0));
        check("fault",      64'(fault),      64'(exp_fault));
        check("fault_code", 64'(fault_code), 64'(exp_code));
        check("rsp_data",   64'(rsp_data),   64'(m_rsp));
        check("ctx_out",    64'(ctx_out),    64'({m_ctx[2], m_ctx[1], m_ctx[0]}));
        check("xfer_count", 64'(xfer_log.size()), 64'(exp_log.size()));
        for (int i = 0; i < exp_log.size(); i++) begin
            if (i < xfer_log.size()) begin
                check("xfer_we",   64'(xfer_log[i].we),   64'(exp_log[i].we));
                check("xfer_addr", 64'(xfer_log[i].addr), 64'(exp_log[i].addr));
                check("xfer_data", 64'(xfer_log[i].data), 64'(exp_log[i].data));
            end
        end

        @(negedge clk);
        check("rsp_pulse", 64'(rsp_valid), 64'(0));
        check("ready_back", 64'(cmd_ready), 64'(1));
        check("sp",        64'(sp),        64'(m_sp));
        check("depth",     64'(depth),     64'(TOP - m_sp));
        check("max_depth", 64'(max_depth), 64'(m_max));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n;
        int          r;
        logic [2:0]  op;
        logic [15:0] data;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        ctx_in    = '0;
        mem_rdata = '0;
        m_reset();
        repeat (3) @(negedge clk);
        check("rst_mem_req", 64'(mem_req), 64'(0));
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_sp",         64'(sp),         64'(16'h0400));
        check("rst_depth",      64'(depth),      64'(0));
        check("rst_max",        64'(max_depth),  64'(0));
        check("rst_ready",      64'(cmd_ready),  64'(1));
        check("rst_rsp_valid",  64'(rsp_valid),  64'(0));
        check("rst_fault",      64'(fault),      64'(0));
        check("rst_fault_code", 64'(fault_code), 64'(0));
        check("rst_rsp_data",   64'(rsp_data),   64'(0));
        check("rst_ctx_out",    64'(ctx_out),    64'(0));

        // Underflow from reset: no memory traffic, SP unchanged.
        do_cmd(3'd1, 16'h0000, '0, 1'b0);
        check("pop_empty_sp", 64'(sp), 64'(16'h0400));

        // Single push with zero-wait memory.
        do_cmd(3'd0, 16'hBEEF, '0, 1'b0);
        check("push_sp",    64'(sp),    64'(16'h03FF));
        check("push_depth", 64'(depth), 64'(1));
        do_cmd(3'd1, 16'h0000, '0, 1'b0);
        check("pop_value", 64'(rsp_data), 64'(16'hBEEF));

        // Context save/restore with two wait cycles per word.
        mem_wait = 2;
        do_cmd(3'd2, 16'h0000, {16'h0033, 16'h0022, 16'h0011}, 1'b0);
        if (xfer_log.size() == 3) begin
            check("save_a0", 64'(xfer_log[0].addr), 64'(16'h03FF));
            check("save_a2", 64'(xfer_log[2].addr), 64'(16'h03FD));
            check("save_d2", 64'(xfer_log[2].data), 64'(16'h0033));
        end
        do_cmd(3'd3, 16'h0000, '0, 1'b1);
        check("restore_ctx", 64'(ctx_out),   64'({16'h0033, 16'h0022, 16'h0011}));
        check("restore_sp",  64'(sp),        64'(16'h0400));
        check("restore_max", 64'(max_depth), 64'(3));

        // Fill to capacity, overflow, then SETSP bounds.
        mem_wait = 0;
        for (int i = 0; i < DEPTH; i++) do_cmd(3'd0, 16'(i * 3 + 1), '0, 1'b0);
        do_cmd(3'd0, 16'h1234, '0, 1'b0);
        check("full_code",  64'(depth), 64'(64));
        check("full_sp",    64'(sp),    64'(16'h03C0));
        do_cmd(3'd4, 16'h03BF, '0, 1'b0);
        check("setsp_low_sp", 64'(sp), 64'(16'h03C0));
        do_cmd(3'd4, 16'h0400, '0, 1'b0);
        check("setsp_top_depth", 64'(depth),     64'(0));
        check("setsp_keeps_max", 64'(max_depth), 64'(64));
        do_cmd(3'd5, 16'h0000, '0, 1'b0);

        // Reset while SAVE waits on its first ack.
        mem_wait = 5;
        do_cmd(3'd0, 16'hAAAA, '0, 1'b0);
        mem_wait = 5;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        ctx_in    = {16'h0C0C, 16'h0B0B, 16'h0A0A};
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin @(negedge clk); n++; end
        check("abort_req_seen", 64'(mem_req), 64'(1));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_req_drop", 64'(mem_req), 64'(0));
        check("abort_sp",       64'(sp),      64'(16'h0400));
        m_reset();
        repeat (2) begin
            @(negedge clk);
            check("abort_no_rsp", 64'(rsp_valid), 64'(0));
        end
        #2 rst = 1'b0;
        @(negedge clk);
        check("abort_ready",   64'(cmd_ready), 64'(1));
        check("abort_no_rsp2", 64'(rsp_valid), 64'(0));
        check("abort_max",     64'(max_depth), 64'(0));

        // Stray acks while idle must not move SP.
        spur_ack = 1'b1;
        repeat (3) @(negedge clk);
        spur_ack = 1'b0;
        check("stray_ack_sp", 64'(sp), 64'(16'h0400));

        // Random command stream.
        for (int k = 0; k < 400; k++) begin
            mem_wait = $urandom_range(0, 2);
            r = $urandom_range(0, 99);
            data = 16'($urandom);
            if      (r < 35) op = 3'd0;
            else if (r < 55) op = 3'd1;
            else if (r < 67) op = 3'd2;
            else if (r < 79) op = 3'd3;
            else if (r < 92) begin
                op = 3'd4;
                if ($urandom_range(0, 1) == 1)
                    data = 16'(TOP - DEPTH - 2 + int'($urandom_range(0, DEPTH + 4)));
            end else op = 3'($urandom_range(5, 7));
            do_cmd(op, data, {16'($urandom), 16'($urandom), 16'($urandom)},
                   $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
